// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: samples CS_L/SCLK/DATA on clk, shifts MSB-first frames and
// presents words on a valid/ready port. Define SPI_RX_SYNC_EN for a two-flop pin synchronizer.
module spi_rx_deser #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs_l,
  input  logic                  spi_sclk,
  input  logic                  spi_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [4:0]            bit_count
);

`ifdef SPI_RX_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  logic [L-1:0]          cs_pipe_q, cs_pipe_d;
  logic [L-1:0]          sclk_pipe_q, sclk_pipe_d;
  logic [L-1:0]          data_pipe_q, data_pipe_d;
  logic [L-1:0]          prime_q, prime_d;
  logic                  sclk_prev_q, sclk_prev_d;
  state_t                state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic                  cs_s, sclk_s, data_s, sclk_rise, primed;
  logic                  capture, complete;
  logic [DATA_WIDTH-1:0] word;

  assign cs_s      = cs_pipe_q[L-1];
  assign sclk_s    = sclk_pipe_q[L-1];
  assign data_s    = data_pipe_q[L-1];
  assign primed    = prime_q[L-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign word      = {shift_q[DATA_WIDTH-2:0], data_s};

  // Sample stage; prime tracks when the pipe holds real pin samples rather than reset values,
  // so a reset in the middle of a frame waits for a genuine CS_L high before resyncing.
  always_comb begin
`ifdef SPI_RX_SYNC_EN
    cs_pipe_d   = {cs_pipe_q[0], spi_cs_l};
    sclk_pipe_d = {sclk_pipe_q[0], spi_sclk};
    data_pipe_d = {data_pipe_q[0], spi_data};
    prime_d     = {prime_q[0], 1'b1};
`else
    cs_pipe_d   = spi_cs_l;
    sclk_pipe_d = spi_sclk;
    data_pipe_d = spi_data;
    prime_d     = 1'b1;
`endif
    sclk_prev_d = sclk_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    capture     = 1'b0;
    complete    = 1'b0;
    case (state_q)
      WAIT_IDLE: if (primed && cs_s) state_d = IDLE;
      IDLE: begin
        bit_cnt_d = '0;
        if (!cs_s) begin
          state_d = SHIFT;
          capture = sclk_rise;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          shift_d     = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else begin
          capture = sclk_rise;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    if (capture) begin
      shift_d = word;
      if (bit_cnt_q == LAST_BIT) begin
        complete  = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  // A completing word wins over acceptance; a full, unaccepted register drops the new word.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_pipe_q   <= '1;
      sclk_pipe_q <= '0;
      data_pipe_q <= '0;
      prime_q     <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cs_pipe_q   <= cs_pipe_d;
      sclk_pipe_q <= sclk_pipe_d;
      data_pipe_q <= data_pipe_d;
      prime_q     <= prime_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: drives the SPI word driver cadence and checks words,
// error pulses and output latency with immediate assertions.
module tb_spi_rx_deser;
`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          spi_cs_l = 1'b1;
  logic          spi_sclk = 1'b0;
  logic          spi_data = 1'b0;
  logic          rx_ready = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid, frame_err, overrun;
  logic [4:0]    bit_count;

  int n_chk = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [DW-1:0] got_q[$];

  spi_rx_deser #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk), .spi_data(spi_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: accepted words and one-cycle error pulses
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    spi_data = b;
    spi_sclk = 1'b0;
    tick();
    spi_sclk = 1'b1;
    tick();
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int n);
    spi_cs_l = 1'b0;
    for (int i = 0; i < n; i++) send_bit(w[DW-1-i]);
  endtask

  task automatic end_frame(input int idle);
    spi_sclk = 1'b0;
    spi_cs_l = 1'b1;
    repeat (idle) tick();
  endtask

  task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
    logic [DW-1:0] w;
    if (got_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      w = got_q.pop_front();
      chk(tag, 32'(w), 32'(exp));
    end
  endtask

  initial begin
    int fe0, ov0;
    logic [DW-1:0] w;

    // Reset state
    repeat (3) tick();
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_bit_count", 32'(bit_count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    repeat (5) tick();

    // 1: A5C3, ready=1, exact completion latency
    fe0 = fe_cnt; ov0 = ov_cnt;
    w = 16'hA5C3;
    send_bits(w, DW - 1);
    spi_data = w[0];
    spi_sclk = 1'b0;
    tick();
    spi_sclk = 1'b1;
    tick();                                   // edge N
    chk("t1_valid_at_N", 32'(rx_valid), 32'd0);
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk("t1_valid_early", 32'(rx_valid), 32'd0);
    end
    tick();                                   // edge N+LAT
    chk("t1_valid_rise", 32'(rx_valid), 32'd1);
    chk("t1_rx_data", 32'(rx_data), 32'hA5C3);
    chk("t1_bit_count", 32'(bit_count), 32'd0);
    end_frame(1);
    chk("t1_valid_one_clk", 32'(rx_valid), 32'd0);
    chk("t1_data_held", 32'(rx_data), 32'hA5C3);
    repeat (4) tick();
    pop_chk("t1_word", 16'hA5C3);
    chk("t1_no_extra", 32'(got_q.size()), 32'd0);
    chk("t1_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("t1_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // 2: overrun with ready=0
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_bits(16'h1234, DW);
    end_frame(LAT + 3);
    chk("t2_valid_held", 32'(rx_valid), 32'd1);
    chk("t2_first_word", 32'(rx_data), 32'h1234);
    send_bits(16'hFFFF, DW);
    end_frame(LAT + 3);
    chk("t2_overrun_once", 32'(ov_cnt - ov0), 32'd1);
    chk("t2_old_word_kept", 32'(rx_data), 32'h1234);
    chk("t2_still_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    tick();
    chk("t2_accepted", 32'(rx_valid), 32'd0);
    pop_chk("t2_word", 16'h1234);
    chk("t2_no_extra", 32'(got_q.size()), 32'd0);
    chk("t2_no_frame_err", 32'(fe_cnt - fe0), 32'd0);

    // 3: frame error after 7 bits, then a clean frame
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_bits(16'hF0F0, 7);
    spi_sclk = 1'b0;
    repeat (LAT) tick();
    chk("t3_bit_count7", 32'(bit_count), 32'd7);
    end_frame(LAT + 3);
    chk("t3_frame_err_once", 32'(fe_cnt - fe0), 32'd1);
    chk("t3_valid_low", 32'(rx_valid), 32'd0);
    chk("t3_bit_count_clr", 32'(bit_count), 32'd0);
    send_bits(16'h0F0F, DW);
    end_frame(LAT + 3);
    pop_chk("t3_word", 16'h0F0F);
    chk("t3_no_extra", 32'(got_q.size()), 32'd0);
    chk("t3_fe_total", 32'(fe_cnt - fe0), 32'd1);

    // 4: contiguous frames with CS_L held low
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_bits(16'h8001, DW);
    send_bits(16'h7FFE, DW);
    end_frame(LAT + 3);
    pop_chk("t4_word0", 16'h8001);
    pop_chk("t4_word1", 16'h7FFE);
    chk("t4_no_extra", 32'(got_q.size()), 32'd0);
    chk("t4_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("t4_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // 5: reset mid-frame, then resync after CS_L high
    send_bits(16'hBEEF, 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    w = 16'h5A5A;
    for (int i = 0; i < 11; i++) send_bit(w[10-i]);
    spi_sclk = 1'b0;
    repeat (LAT + 3) tick();
    chk("t5_nothing_valid", 32'(rx_valid), 32'd0);
    chk("t5_nothing_got", 32'(got_q.size()), 32'd0);
    end_frame(LAT + 3);
    send_bits(16'hBEEF, DW);
    end_frame(LAT + 3);
    pop_chk("t5_word", 16'hBEEF);
    chk("t5_no_extra", 32'(got_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
